// File: rtl/conv_maxpool_stream_pkg.sv
// Shared pixel type and signed-max helper for the conv max-pool stream stage.
package conv_pool_pkg;
  localparam int DATA_W = 16;
  localparam int POOL_K = 3;
  localparam int POOL_S = 2;

  typedef logic signed [DATA_W-1:0] pix_t;

  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/conv_maxpool_stream_if.sv
// Input/output pixel stream bundle; slave is the pooling block, master the environment.
interface conv_maxpool_stream_if;
  import conv_pool_pkg::*;
  logic in_valid;
  logic in_ready;
  pix_t in_data;
  logic out_valid;
  logic out_ready;
  pix_t out_data;
  logic out_last;
  logic frame_done;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, frame_done
  );
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, frame_done
  );
endinterface

// File: rtl/conv_maxpool_rowbuf.sv
// One row of vertical partial maxima; combinational read, registered write.
module conv_maxpool_rowbuf
  import conv_pool_pkg::*;
#(
  parameter int DEPTH = 27,
  parameter int AW    = 5
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr,
  output pix_t          rd_data,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  pix_t          wr_data
);
  pix_t mem [DEPTH];

  // Addresses past DEPTH only occur on cycles whose read result is ignored.
  assign rd_data = (int'(rd_addr) < DEPTH) ? mem[rd_addr] : '0;

  always_ff @(posedge clk) begin
    if (wr_en && (int'(wr_addr) < DEPTH)) mem[wr_addr] <= wr_data;
  end
endmodule

// File: rtl/conv_maxpool_stream.sv
// 3x3 stride-2 streaming max pool over a raster pixel stream.
// Optional CONV_MAXPOOL_RELU_EN clamps negative inputs to zero before pooling.
module conv_maxpool_stream
  import conv_pool_pkg::*;
#(
  parameter int IN_H = 55,
  parameter int IN_W = 55
) (
  input  logic                  clk,
  input  logic                  rst_n,
  conv_maxpool_stream_if.slave  bus
);
  localparam int OUT_H = (IN_H - 1) / 2;
  localparam int OUT_W = (IN_W - 1) / 2;
  localparam int XW    = $clog2(IN_W);
  localparam int YW    = $clog2(IN_H);
  localparam int AW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam logic [XW-2:0] K_ONE = 1;

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  pix_t          hacc, v, h, rb_q, pooled, rb_wdata;
  logic          in_fire, out_fire, col_done, emit, x_last, y_last;
  logic [AW-1:0] k;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign out_fire     = bus.out_valid && bus.out_ready;

`ifdef CONV_MAXPOOL_RELU_EN
  assign v = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
  assign v = bus.in_data;
`endif

  assign x_last = (x == XW'(2 * OUT_W));
  assign y_last = (y == YW'(2 * OUT_H));

  // Even column > 0 closes window k and also opens window k+1.
  assign h        = smax(hacc, v);
  assign col_done = in_fire && (x != '0) && !x[0];
  assign k        = AW'(x[XW-1:1] - K_ONE);

  assign pooled   = smax(rb_q, h);
  assign emit     = col_done && (y != '0) && !y[0];
  assign rb_wdata = ((y != '0) && y[0]) ? pooled : h;

  conv_maxpool_rowbuf #(.DEPTH(OUT_W), .AW(AW)) u_rowbuf (
    .clk     (clk),
    .rd_addr (k),
    .rd_data (rb_q),
    .wr_en   (col_done),
    .wr_addr (k),
    .wr_data (rb_wdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x    <= '0;
      y    <= '0;
      hacc <= '0;
    end else if (in_fire) begin
      hacc <= x[0] ? h : v;
      if (x_last) begin
        x <= '0;
        y <= y_last ? '0 : y + YW'(1);
      end else begin
        x <= x + XW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      bus.out_last   <= 1'b0;
      bus.frame_done <= 1'b0;
    end else begin
      bus.frame_done <= out_fire && bus.out_last;
      if (emit) begin
        bus.out_valid <= 1'b1;
        bus.out_data  <= pooled;
        bus.out_last  <= x_last && y_last;
      end else if (out_fire) begin
        bus.out_valid <= 1'b0;
        bus.out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_conv_maxpool_stream.sv
// Scoreboard bench: window-max reference model feeds a queue, a monitor pops on each output beat.
module tb_conv_maxpool_stream;
  import conv_pool_pkg::*;
  localparam int IN_H = 55, IN_W = 55;
  localparam int OUT_H = (IN_H - 1) / 2, OUT_W = (IN_W - 1) / 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  conv_maxpool_stream_if bus ();
  conv_maxpool_stream #(.IN_H(IN_H), .IN_W(IN_W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct { int d; bit last; } exp_t;
  exp_t sb[$];
  int   n_chk = 0, n_fail = 0, n_done = 0, exp_done = 0;
  bit   gaps = 0;
  int   bp_mode = 0;
  int   img [IN_H][IN_W];

  task automatic check(input string nm, input int act, input int req);
    n_chk++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Downstream ready: always high, or high one cycle in three on average.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = (bp_mode == 0) ? 1'b1 : ($urandom_range(0, 2) == 0);
    end
  end

  // Monitor
  initial begin
    exp_t e;
    bit   stalled = 0;
    int   held = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_last", int'(bus.out_last), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_frame_done", int'(bus.frame_done), 0);
        stalled = 0;
      end else begin
        check("in_ready", int'(bus.in_ready), int'(!(bus.out_valid && !bus.out_ready)));
        if (stalled) begin
          check("held_valid", int'(bus.out_valid), 1);
          check("held_data", int'($signed(bus.out_data)), held);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (sb.size() == 0) check("unexpected_out", int'($signed(bus.out_data)), -99999);
          else begin
            e = sb.pop_front();
            check("out_data", int'($signed(bus.out_data)), e.d);
            check("out_last", int'(bus.out_last), int'(e.last));
          end
        end
        if (bus.frame_done) n_done++;
        stalled = bus.out_valid && !bus.out_ready;
        held    = int'($signed(bus.out_data));
      end
    end
  end

  task automatic send_pix(input int v);
    bit rdy;
    int t;
    if (gaps) while ($urandom_range(0, 3) == 0) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = pix_t'(v);
    t = 0;
    do begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 2000);
    bus.in_valid = 1'b0;
    if (!rdy) begin
      check("in_ready_timeout", 0, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $fatal(1, "stalled input");
    end
  endtask

  // kind 0: ramp, 1: constant -5, 2: single spike at (2,2)
  task automatic run_frame(input int kind, input int npix);
    int m, p;
    for (int yy = 0; yy < IN_H; yy++)
      for (int xx = 0; xx < IN_W; xx++)
        case (kind)
          0:       img[yy][xx] = yy * IN_W + xx;
          1:       img[yy][xx] = -5;
          default: img[yy][xx] = (yy == 2 && xx == 2) ? 100 : 0;
        endcase
    for (int r = 0; r < OUT_H; r++)
      for (int c = 0; c < OUT_W; c++) begin
        m = -(1 << 30);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++) begin
            p = img[2*r+i][2*c+j];
`ifdef CONV_MAXPOOL_RELU_EN
            if (p < 0) p = 0;
`endif
            if (p > m) m = p;
          end
        sb.push_back('{d: m, last: (r == OUT_H-1 && c == OUT_W-1)});
      end
    if (npix == IN_H * IN_W) exp_done++;
    for (int n = 0; n < npix; n++) send_pix(img[n / IN_W][n % IN_W]);
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    run_frame(0, IN_H * IN_W);
    run_frame(1, IN_H * IN_W);
    gaps = 1;
    run_frame(2, IN_H * IN_W);
    bp_mode = 1;
    run_frame(0, IN_H * IN_W);

    // Reset in the middle of a frame, then a clean frame.
    run_frame(0, 1000);
    rst_n = 1'b0;
    sb.delete();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame(0, IN_H * IN_W);

    gaps = 0;
    bp_mode = 0;
    run_frame(0, IN_H * IN_W);
    run_frame(0, IN_H * IN_W);

    t = 0;
    while (sb.size() != 0 && t < 5000) begin
      @(posedge clk); t++;
    end
    check("drain_remaining", sb.size(), 0);
    repeat (4) @(posedge clk);
    check("frame_done_count", n_done, exp_done);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/conv_maxpool_stream.md
Name: conv_maxpool_stream

Overview:
- Streaming downstream stage for the 11x11/stride-4 convolution.
- Consumes the 55x55 convolution output as a raster-order pixel stream over a valid/ready handshake.
- Applies 3x3, stride-2 max pooling and emits a 27x27 raster stream to the next layer.
- Keeps only one row of partial maxima, so no full-frame buffering is needed.

Parameters:
- DATA_W, 16, pixel width; signed two's complement.
- IN_H, 55, input rows; must be odd and >= 3.
- IN_W, 55, input columns; must be odd and >= 3.
- OUT_H, (IN_H-1)/2, output rows; derived localparam, not overridable.
- OUT_W, (IN_W-1)/2, output columns; derived localparam, not overridable.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input pixel valid.
- in_ready  out  1  block can accept an input pixel.
- in_data  in  DATA_W  input pixel, signed, raster order starting at (0,0).
- out_valid  out  1  pooled pixel valid.
- out_ready  in  1  downstream accepts the pooled pixel.
- out_data  out  DATA_W  pooled pixel, signed.
- out_last  out  1  qualifies the final pooled pixel of a frame, (OUT_H-1,OUT_W-1).
- frame_done  out  1  one-cycle pulse when the out_last beat is accepted.

Behaviour:
- Reset is asynchronous and active-low, one clock. While rst_n=0: row/col counters=0, out_valid=0, out_data=0, out_last=0, frame_done=0, hacc=0. Row-buffer contents are don't-care.
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready, combinational. This allows accept and drain in the same cycle.
- Counters: x in 0..IN_W-1, y in 0..IN_H-1, advance on each input transfer.
  - x wraps to 0 at IN_W-1, then y increments.
  - y wraps to 0 after (IN_H-1, IN_W-1); the next frame begins with no idle cycle.
- Horizontal stage (register hacc), on each input pixel v:
  - x==0: hacc=v.
  - x odd: hacc=max(hacc,v).
  - x even and >0: h=max(hacc,v) is produced for column k=x/2-1, then hacc=v. The shared column feeds both windows.
- Vertical stage (row buffer rb[0..OUT_W-1]), on each produced h for column k:
  - y==0: rb[k]=h.
  - y odd: rb[k]=max(rb[k],h).
  - y even and >0: out_data<=max(rb[k],h), out_valid<=1, rb[k]<=h.
- Latency: 1 cycle from the accepted input pixel (y even >0, x even >0) to out_valid.
- out_valid is held, with out_data and out_last stable, until accepted.
- A frame yields exactly OUT_H*OUT_W outputs. Output row r is produced during input row 2r+2.
- Comparison is signed. Max of equal values returns that value. No width growth.
- out_last=1 on the output produced at input (IN_H-1, IN_W-1).
- Back-pressure: if out_valid && !out_ready, in_ready=0. No input is lost and none is accepted early.
- in_valid low for any number of cycles stalls all state.

Optional Feature:
- Macro: CONV_MAXPOOL_RELU_EN.
- Defined: each accepted in_data is replaced by 0 when its sign bit is 1, before entering the horizontal stage. This fuses ReLU, giving out_data >= 0.
- Undefined: raw signed values are pooled; there is no clamping logic.

Decomposition:
- Package conv_pool_pkg:
  - DATA_W constant.
  - typedef pix_t = logic signed [DATA_W-1:0].
  - Function smax(pix_t a, pix_t b).
  - Localparams POOL_K=3 and POOL_S=2 (documentation only; fixed).
- Sub-module conv_maxpool_rowbuf: OUT_W x pix_t storage with one read address, one write address and a write enable. Implemented as registers or 1R1W RAM; combinational read.
- Top level holds the counters, hacc, output register and handshake.

Test Plan:
- Ramp frame: in_data = y*55+x, out_ready=1 continuous.
  - Expect 729 outputs, out(r,c)=(2r+2)*55+2c+2, i.e. out(0,0)=112 and out(26,26)=3024.
  - out_last only on beat 729, one frame_done pulse.
- Constant frame -5 with ReLU macro undefined: all 729 outputs = -5 (0xFFFB). With CONV_MAXPOOL_RELU_EN defined: all outputs = 0.
- Single spike: all pixels 0 except (2,2)=100.
  - Output (0,0)=100, (0,1)=100, (1,0)=100, (1,1)=100; all others 0. This checks the shared row/column.
- Back-pressure: out_ready toggles 1-in-3 and in_valid is random with the ramp frame.
  - Identical output sequence to the first test.
  - in_ready=0 exactly while out_valid && !out_ready.
  - Held out_data never changes while stalled.
- Reset mid-frame: assert rst_n=0 after 1000 inputs, release, then send a full ramp frame.
  - out_valid=0 during reset.
  - Subsequent output matches the first test exactly.
- Back-to-back frames: two ramp frames with no gap. Expect 1458 outputs, two frame_done pulses, and the second frame's outputs identical to the first's.
